// File: rtl/mem_stage_access.sv
// MEM-stage access controller: issues loads/stores to a valid/ready data memory and stalls
// the pipeline until the access completes. Optional timeout abort under MEM_TIMEOUT_EN.
module mem_stage_access #(
    parameter int unsigned ADDR_OFFSET    = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  dest_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] st_val_in,
    input  logic [31:0] pc_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        wb_en_in,
    output logic        dm_req_valid,
    output logic        dm_req_we,
    output logic [31:0] dm_req_addr,
    output logic [31:0] dm_req_wdata,
    input  logic        dm_req_ready,
    input  logic        dm_rsp_valid,
    input  logic [31:0] dm_rsp_rdata,
    output logic [4:0]  dest_out_mem,
    output logic [31:0] alu_result_out_mem,
    output logic [31:0] data_memory_out,
    output logic [31:0] pc_out,
    output logic        mem_r_en_out_mem,
    output logic        wb_en_out_mem,
    output logic        mem_stall,
    output logic        mem_err
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;
    localparam logic [XLEN-1:0] ABORT_DATA = 32'hDEADBEEF;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_stage_access: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic [XLEN-1:0]  alu_result;
        logic [XLEN-1:0]  st_val;
        logic [XLEN-1:0]  pc;
        logic             rd;
        logic             wr;
        logic             wb_en;
    } lat_t;

    state_t          state_q, state_d;
    lat_t            lat_q, lat_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            timeout_hit;
    logic            mem_op_c;
    logic [XLEN-1:0] addr_diff_c;

    assign mem_op_c    = mem_r_en_in | mem_w_en_in;
    assign addr_diff_c = lat_q.alu_result - XLEN'(ADDR_OFFSET);

    // State and latched instruction fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Cycles spent in REQ+WAIT for the current access
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == IDLE && state_d == REQ) begin
            cnt_q <= '0;
        end else if (state_q == REQ || state_q == WAIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next state, memory request and MEM/WB outputs
    always_comb begin
        state_d            = state_q;
        lat_d              = lat_q;
        rdata_d            = rdata_q;
        err_d              = 1'b0;
        dm_req_valid       = 1'b0;
        dm_req_we          = lat_q.wr;
        dm_req_addr        = {addr_diff_c[XLEN-1:2], 2'b00};
        dm_req_wdata       = lat_q.st_val;
        dest_out_mem       = '0;
        alu_result_out_mem = '0;
        data_memory_out    = '0;
        pc_out             = '0;
        mem_r_en_out_mem   = 1'b0;
        wb_en_out_mem      = 1'b0;
        mem_stall          = 1'b0;
        mem_err            = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_op_c) begin
                    mem_stall        = 1'b1;
                    lat_d.dest       = dest_in;
                    lat_d.alu_result = alu_result_in;
                    lat_d.st_val     = st_val_in;
                    lat_d.pc         = pc_in;
                    lat_d.rd         = mem_r_en_in;
                    lat_d.wr         = mem_w_en_in & ~mem_r_en_in;
                    lat_d.wb_en      = wb_en_in;
                    rdata_d          = '0;
                    state_d          = REQ;
                end else begin
                    dest_out_mem       = dest_in;
                    alu_result_out_mem = alu_result_in;
                    pc_out             = pc_in;
                    mem_r_en_out_mem   = mem_r_en_in;
                    wb_en_out_mem      = wb_en_in;
                end
            end
            REQ: begin
                mem_stall    = 1'b1;
                dm_req_valid = 1'b1;
                if (dm_req_ready) begin
                    state_d = lat_q.wr ? DONE : WAIT;
                end
                // A load accepted exactly at the limit is still aborted: its response is dropped.
                if (timeout_hit && !(dm_req_ready && lat_q.wr)) begin
                    state_d = DONE;
                    rdata_d = ABORT_DATA;
                    err_d   = 1'b1;
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (dm_rsp_valid) begin
                    rdata_d = dm_rsp_rdata;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    rdata_d = ABORT_DATA;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                dest_out_mem       = lat_q.dest;
                alu_result_out_mem = lat_q.alu_result;
                data_memory_out    = rdata_q;
                pc_out             = lat_q.pc;
                mem_r_en_out_mem   = lat_q.rd;
                wb_en_out_mem      = lat_q.wb_en;
                mem_err            = err_q;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // While reset is held everything downstream sees the zeroed latches.
        if (rst) begin
            dm_req_valid       = 1'b0;
            dest_out_mem       = '0;
            alu_result_out_mem = '0;
            data_memory_out    = '0;
            pc_out             = '0;
            mem_r_en_out_mem   = 1'b0;
            wb_en_out_mem      = 1'b0;
            mem_stall          = 1'b0;
            mem_err            = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access with a latency-programmable memory responder and an
// expected-result queue for MEM/WB outputs. Define MEM_TIMEOUT_EN to also exercise the abort path.
module tb_mem_stage_access;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic        clk;
    logic        rst;
    logic [4:0]  dest_in;
    logic [31:0] alu_result_in;
    logic [31:0] st_val_in;
    logic [31:0] pc_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic        wb_en_in;
    logic        dm_req_valid;
    logic        dm_req_we;
    logic [31:0] dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic        dm_req_ready;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_rdata;
    logic [4:0]  dest_out_mem;
    logic [31:0] alu_result_out_mem;
    logic [31:0] data_memory_out;
    logic [31:0] pc_out;
    logic        mem_r_en_out_mem;
    logic        wb_en_out_mem;
    logic        mem_stall;
    logic        mem_err;

    mem_stage_access #(
        .ADDR_OFFSET   (1024),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .dest_in           (dest_in),
        .alu_result_in     (alu_result_in),
        .st_val_in         (st_val_in),
        .pc_in             (pc_in),
        .mem_r_en_in       (mem_r_en_in),
        .mem_w_en_in       (mem_w_en_in),
        .wb_en_in          (wb_en_in),
        .dm_req_valid      (dm_req_valid),
        .dm_req_we         (dm_req_we),
        .dm_req_addr       (dm_req_addr),
        .dm_req_wdata      (dm_req_wdata),
        .dm_req_ready      (dm_req_ready),
        .dm_rsp_valid      (dm_rsp_valid),
        .dm_rsp_rdata      (dm_rsp_rdata),
        .dest_out_mem      (dest_out_mem),
        .alu_result_out_mem(alu_result_out_mem),
        .data_memory_out   (data_memory_out),
        .pc_out            (pc_out),
        .mem_r_en_out_mem  (mem_r_en_out_mem),
        .wb_en_out_mem     (wb_en_out_mem),
        .mem_stall         (mem_stall),
        .mem_err           (mem_err)
    );

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] data;
        logic [31:0] pc;
        logic        mem_r;
        logic        wb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    // Memory responder knobs, written by the stimulus
    int          ready_lat = 0;
    int          rsp_lat   = 0;
    logic [31:0] rsp_data  = '0;

    int   wcnt      = 0;
    int   rcnt      = 0;
    bit   accepting = 0;
    bit   pend      = 0;
    logic we_l      = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Memory responder: drives ready/rsp 2 time units after each rising edge
    initial begin
        dm_req_ready = 1'b0;
        dm_rsp_valid = 1'b0;
        dm_rsp_rdata = 32'hBADBAD00;
        forever begin
            @(posedge clk);
            #2;
            if (accepting) begin
                accepting = 0;
                if (!we_l) begin
                    pend = 1;
                    rcnt = rsp_lat;
                end
            end
            dm_rsp_valid = 1'b0;
            dm_rsp_rdata = 32'hBADBAD00;
            if (pend) begin
                if (rcnt == 0) begin
                    dm_rsp_valid = 1'b1;
                    dm_rsp_rdata = rsp_data;
                    pend = 0;
                end else begin
                    rcnt--;
                end
            end
            dm_req_ready = 1'b0;
            if (dm_req_valid) begin
                if (wcnt >= ready_lat) begin
                    dm_req_ready = 1'b1;
                    accepting    = 1;
                    we_l         = dm_req_we;
                    wcnt         = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input bit ok, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        if (ok) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] d, input logic [31:0] a, input logic [31:0] s,
                         input logic [31:0] p, input logic r, input logic w, input logic wb);
        dest_in       = d;
        alu_result_in = a;
        st_val_in     = s;
        pc_in         = p;
        mem_r_en_in   = r;
        mem_w_en_in   = w;
        wb_en_in      = wb;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, sb.size() != 0, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".dest"},  dest_out_mem === e.dest,        dest_out_mem,       e.dest);
            chk({tag, ".alu"},   alu_result_out_mem === e.alu,   alu_result_out_mem, e.alu);
            chk({tag, ".data"},  data_memory_out === e.data,     data_memory_out,    e.data);
            chk({tag, ".pc"},    pc_out === e.pc,                pc_out,             e.pc);
            chk({tag, ".mem_r"}, mem_r_en_out_mem === e.mem_r,   mem_r_en_out_mem,   e.mem_r);
            chk({tag, ".wb"},    wb_en_out_mem === e.wb,         wb_en_out_mem,      e.wb);
        end
    endtask

    // Single-cycle passthrough instruction
    task automatic alu_op(input string tag, input logic [4:0] d, input logic [31:0] a,
                          input logic [31:0] p, input logic wb);
        exp_t e;
        drive(d, a, 32'h0, p, 1'b0, 1'b0, wb);
        e = '{dest: d, alu: a, data: 32'h0, pc: p, mem_r: 1'b0, wb: wb};
        sb.push_back(e);
        @(negedge clk);
        chk({tag, ".stall"}, mem_stall === 1'b0,    mem_stall,    0);
        chk({tag, ".valid"}, dm_req_valid === 1'b0, dm_req_valid, 0);
        pop_check(tag);
        next_cycle();
    endtask

    // Full memory access; returns one cycle after DONE with idle inputs
    task automatic mem_op(input string tag, input logic [4:0] d, input logic [31:0] a,
                          input logic [31:0] s, input logic [31:0] p, input logic r,
                          input logic w, input logic wb, input logic [31:0] rdat,
                          input int rl, input int ql, input logic [31:0] exp_addr,
                          input logic exp_we, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_reqs, input int exp_stalls);
        exp_t e;
        int   stalls;
        int   reqs;
        bit   done;
        ready_lat = rl;
        rsp_lat   = ql;
        rsp_data  = rdat;
        drive(d, a, s, p, r, w, wb);
        e = '{dest: d, alu: a, data: exp_data, pc: p, mem_r: r, wb: wb};
        sb.push_back(e);
        stalls = 0;
        reqs   = 0;
        done   = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!mem_stall) begin
                done = 1;
                break;
            end
            stalls++;
            chk({tag, ".bubble"},
                {wb_en_out_mem, mem_r_en_out_mem, data_memory_out} === 34'h0,
                {wb_en_out_mem, mem_r_en_out_mem, data_memory_out}, 0);
            if (dm_req_valid) begin
                reqs++;
                chk({tag, ".addr"},  dm_req_addr === exp_addr, dm_req_addr,  exp_addr);
                chk({tag, ".we"},    dm_req_we === exp_we,     dm_req_we,    exp_we);
                chk({tag, ".wdata"}, dm_req_wdata === s,       dm_req_wdata, s);
            end
            next_cycle();
        end
        chk({tag, ".completed"}, done == 1'b1,         done,    1);
        chk({tag, ".reqs"},      reqs == exp_reqs,     reqs,    exp_reqs);
        chk({tag, ".stalls"},    stalls == exp_stalls, stalls,  exp_stalls);
        chk({tag, ".err"},       mem_err === exp_err,  mem_err, exp_err);
        pop_check(tag);
        next_cycle();
        drive(5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drive(5'd8, 32'h10, 32'h0, 32'h100, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset.valid", dm_req_valid === 1'b0,        dm_req_valid,       0);
        chk("reset.stall", mem_stall === 1'b0,           mem_stall,          0);
        chk("reset.err",   mem_err === 1'b0,             mem_err,            0);
        chk("reset.dest",  dest_out_mem === 5'd0,        dest_out_mem,       0);
        chk("reset.alu",   alu_result_out_mem === 32'h0, alu_result_out_mem, 0);
        chk("reset.pc",    pc_out === 32'h0,             pc_out,             0);
        chk("reset.wb",    wb_en_out_mem === 1'b0,       wb_en_out_mem,      0);
        chk("reset.data",  data_memory_out === 32'h0,    data_memory_out,    0);
        next_cycle();
        rst = 1'b0;

        alu_op("alu1", 5'd8, 32'h10, 32'h100, 1'b1);

        mem_op("ld1", 5'd3, 32'd1032, 32'h0, 32'h104, 1'b1, 1'b0, 1'b1, 32'hCAFE0001,
               0, 0, 32'd8, 1'b0, 32'hCAFE0001, 1'b0, 1, 3);

        mem_op("st1", 5'd4, 32'd1028, 32'h55, 32'h108, 1'b0, 1'b1, 1'b0, 32'h0,
               4, 0, 32'd4, 1'b1, 32'h0, 1'b0, 5, 6);

        // Back-to-back loads: unaligned address, then one that wraps below the offset
        drive(5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        mem_op("ld2a", 5'd5, 32'd1035, 32'h0, 32'h10C, 1'b1, 1'b0, 1'b1, 32'h11111111,
               0, 0, 32'd8, 1'b0, 32'h11111111, 1'b0, 1, 3);
        mem_op("ld2b", 5'd6, 32'd4, 32'h0, 32'h110, 1'b1, 1'b0, 1'b1, 32'h22222222,
               0, 2, 32'hFFFFFC04, 1'b0, 32'h22222222, 1'b0, 1, 5);

        mem_op("rw", 5'd7, 32'd2000, 32'h77, 32'h114, 1'b1, 1'b1, 1'b1, 32'h33333333,
               0, 0, 32'h3D0, 1'b0, 32'h33333333, 1'b0, 1, 3);

        mem_op("stwrap", 5'd2, 32'd2, 32'hA5A5A5A5, 32'h118, 1'b0, 1'b1, 1'b0, 32'h0,
               1, 0, 32'hFFFFFC00, 1'b1, 32'h0, 1'b0, 2, 3);

        alu_op("alu2", 5'd31, 32'hFFFFFFFF, 32'h11C, 1'b1);

        // Reset while waiting for a load response; the late response must be ignored
        ready_lat = 0;
        rsp_lat   = 3;
        rsp_data  = 32'h44444444;
        drive(5'd9, 32'd1100, 32'h0, 32'h120, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("rstw.idle_stall", mem_stall === 1'b1, mem_stall, 1);
        next_cycle();
        @(negedge clk);
        chk("rstw.req_valid", dm_req_valid === 1'b1, dm_req_valid, 1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rstw.held_stall", mem_stall === 1'b0,     mem_stall,     0);
        chk("rstw.held_wb",    wb_en_out_mem === 1'b0, wb_en_out_mem, 0);
        next_cycle();
        rst = 1'b0;
        drive(5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstw.after_stall", mem_stall === 1'b0,    mem_stall,    0);
            chk("rstw.after_valid", dm_req_valid === 1'b0, dm_req_valid, 0);
            chk("rstw.after_outs",
                {dest_out_mem, alu_result_out_mem, data_memory_out, pc_out,
                 mem_r_en_out_mem, wb_en_out_mem} === 103'h0,
                {dest_out_mem, alu_result_out_mem, data_memory_out, pc_out,
                 mem_r_en_out_mem, wb_en_out_mem}, 0);
            next_cycle();
        end
        alu_op("alu3", 5'd12, 32'h1234, 32'h124, 1'b1);

`ifdef MEM_TIMEOUT_EN
        mem_op("tmo", 5'd10, 32'd1040, 32'h0, 32'h200, 1'b1, 1'b0, 1'b1, 32'h0,
               1000, 0, 32'd16, 1'b0, 32'hDEADBEEF, 1'b1, 5, 6);
        @(negedge clk);
        chk("tmo.err_pulse_end", mem_err === 1'b0, mem_err, 0);
        next_cycle();
        alu_op("alu4", 5'd1, 32'h5, 32'h204, 1'b1);
`endif

        chk("sb.drained", sb.size() == 0, sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
